// File: rtl/pause_rx_pkg.sv
// pause_rx shared definitions: MAC-control constants, parser states,
// and helpers mapping wire-order fields onto little-endian beat lanes.
package pause_rx_pkg;

    localparam logic [47:0] MAC_CTRL_DA  = 48'h0180C2000001;
    localparam logic [15:0] ETYPE_MACCTL = 16'h8808;
    localparam logic [15:0] OPCODE_PAUSE = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PARAM,
        ST_TAIL,
        ST_DROP
    } state_t;

    // First wire byte lands in the lowest lane of the beat.
    function automatic logic [47:0] lanes48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = v[8*(5-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] lanes16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/pause_timer.sv
// pause_timer: per-quantum prescaler and 16-bit quanta countdown.
// A load restarts the prescaler; clr dominates everything.
module pause_timer
    import pause_rx_pkg::*;
#(
    parameter int QUANTUM_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        clr,
    output logic [15:0] quanta,
    output logic        active
);

    localparam int PW = $clog2(QUANTUM_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(QUANTUM_CYCLES - 1);

    logic [PW-1:0] presc;

    // Quanta countdown with load/refresh; active tracks quanta != 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            quanta <= '0;
            active <= 1'b0;
        end else if (clr) begin
            presc  <= '0;
            quanta <= '0;
            active <= 1'b0;
        end else if (load) begin
            presc  <= '0;
            quanta <= load_val;
            active <= (load_val != 16'd0);
        end else if (quanta != 16'd0) begin
            if (presc == PRESC_LAST) begin
                presc  <= '0;
                quanta <= quanta - 16'd1;
                active <= (quanta != 16'd1);
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pause_rx.sv
// pause_rx: snoops the rx stream for 802.3x PAUSE frames and drives pause_active.
// Define PAUSE_RX_STATS_EN to build the accepted-frame counter (else pause_frames=0).
module pause_rx
    import pause_rx_pkg::*;
#(
    parameter int QUANTUM_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_en,
    input  logic [63:0] axis_tdata,
    input  logic [7:0]  axis_tkeep,
    input  logic        axis_tvalid,
    input  logic        axis_tlast,
    input  logic        axis_tuser,
    output logic        pause_active,
    output logic [15:0] pause_quanta,
    output logic [31:0] pause_frames
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  beat_cnt;
    logic [15:0] pause_time;
    logic        beat0_ok;
    logic        beat1_ok;
    logic        param_ok;
    logic        accept;

    assign beat0_ok = (axis_tdata[47:0] == lanes48(MAC_CTRL_DA))
                    && (axis_tkeep == 8'hFF);
    assign beat1_ok = (axis_tdata[63:32] ==
                       {lanes16(OPCODE_PAUSE), lanes16(ETYPE_MACCTL)})
                    && (axis_tkeep == 8'hFF);
    assign param_ok = (axis_tkeep[1:0] == 2'b11);

    assign accept = axis_tvalid && axis_tlast && (state == ST_TAIL)
                  && axis_tuser && (beat_cnt == 3'd7) && pause_en;

    // Parser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parser next state: header checks per beat; tlast always ends the frame.
    always_comb begin
        state_nxt = state;
        if (axis_tvalid) begin
            if (axis_tlast) begin
                state_nxt = ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE:  state_nxt = beat0_ok ? ST_HDR1  : ST_DROP;
                    ST_HDR1:  state_nxt = beat1_ok ? ST_PARAM : ST_DROP;
                    ST_PARAM: state_nxt = param_ok ? ST_TAIL  : ST_DROP;
                    ST_TAIL:  state_nxt = ST_TAIL;
                    ST_DROP:  state_nxt = ST_DROP;
                    default:  state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Saturating beat counter and pause_time capture from beat 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            pause_time <= '0;
        end else if (axis_tvalid) begin
            if (axis_tlast) begin
                beat_cnt <= '0;
            end else if (beat_cnt != 3'd7) begin
                beat_cnt <= beat_cnt + 3'd1;
            end
            if (state == ST_PARAM) begin
                pause_time <= {axis_tdata[7:0], axis_tdata[15:8]};
            end
        end else if (state == ST_IDLE) begin
            beat_cnt <= '0;
        end
    end

    pause_timer #(
        .QUANTUM_CYCLES(QUANTUM_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (pause_time),
        .clr      (!pause_en),
        .quanta   (pause_quanta),
        .active   (pause_active)
    );

`ifdef PAUSE_RX_STATS_EN
    // Accepted-frame counter, XON included; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_frames <= '0;
        end else if (accept) begin
            pause_frames <= pause_frames + 32'd1;
        end
    end
`else
    assign pause_frames = '0;
`endif

endmodule

// File: tb/tb_pause_rx.sv
// tb_pause_rx: scenario tasks with a scoreboard of expected timer/stat state.
// Works with and without PAUSE_RX_STATS_EN.
module tb_pause_rx;

    localparam int Q = 8;
    localparam logic [47:0] DA  = 48'h0180C2000001;
    localparam logic [15:0] ET  = 16'h8808;
    localparam logic [15:0] OP  = 16'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause_en = 1'b1;
    logic [63:0] axis_tdata = '0;
    logic [7:0]  axis_tkeep = '0;
    logic        axis_tvalid = 1'b0;
    logic        axis_tlast = 1'b0;
    logic        axis_tuser = 1'b0;
    logic        pause_active;
    logic [15:0] pause_quanta;
    logic [31:0] pause_frames;

    typedef struct packed {
        logic [15:0] quanta;
        logic [31:0] frames;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int model_frames = 0;

    always #5 clk = ~clk;

    pause_rx #(.QUANTUM_CYCLES(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .pause_en     (pause_en),
        .axis_tdata   (axis_tdata),
        .axis_tkeep   (axis_tkeep),
        .axis_tvalid  (axis_tvalid),
        .axis_tlast   (axis_tlast),
        .axis_tuser   (axis_tuser),
        .pause_active (pause_active),
        .pause_quanta (pause_quanta),
        .pause_frames (pause_frames)
    );

    function automatic logic [31:0] exp_frames();
`ifdef PAUSE_RX_STATS_EN
        return 32'(model_frames);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic u);
        axis_tdata  = d;
        axis_tkeep  = k;
        axis_tvalid = 1'b1;
        axis_tlast  = l;
        axis_tuser  = u;
        @(posedge clk);
        #1;
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [15:0] et,
                              input logic [15:0] op, input logic [15:0] pt,
                              input int nb, input logic u, input bit gap,
                              input bit drop_en, input logic [15:0] exp_q,
                              input string name);
        bit          acc;
        exp_t        e;
        logic [63:0] d;
        acc = (da == DA) && (et == ET) && (op == OP) && (nb >= 8)
            && u && !drop_en && pause_en;
        if (acc) model_frames++;
        e.quanta = exp_q;
        e.frames = exp_frames();
        sb.push_back(e);
        for (int i = 0; i < nb; i++) begin
            case (i)
                0: d = {16'h1122, da[7:0], da[15:8], da[23:16],
                        da[31:24], da[39:32], da[47:40]};
                1: d = {op[7:0], op[15:8], et[7:0], et[15:8], 32'h55667788};
                2: d = {48'h0, pt[7:0], pt[15:8]};
                default: d = {32'hA5A50000, 32'(i)};
            endcase
            if (i == nb - 1 && drop_en) pause_en = 1'b0;
            beat(d, 8'hFF, (i == nb - 1), (i == nb - 1) ? u : 1'b0);
            if (gap && i != nb - 1) tick(1);
        end
        e = sb.pop_front();
        checks++;
        if (pause_quanta !== e.quanta) begin
            failures++;
            $display("FAIL %s_quanta got=%h exp=%h", name, pause_quanta, e.quanta);
        end
        checks++;
        if (pause_frames !== e.frames) begin
            failures++;
            $display("FAIL %s_frames got=%0d exp=%0d", name, pause_frames, e.frames);
        end
    endtask

    task automatic measure(output int n);
        n = 0;
        while (pause_active === 1'b1 && n < 2000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic clear_timer();
        pause_en = 1'b0;
        tick(1);
        pause_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if (pause_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_active got=%b exp=0", pause_active);
        end
        checks++;
        if (pause_quanta !== 16'd0) begin
            failures++;
            $display("FAIL reset_quanta got=%h exp=0", pause_quanta);
        end
        checks++;
        if (pause_frames !== 32'd0) begin
            failures++;
            $display("FAIL reset_frames got=%0d exp=0", pause_frames);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int n;
        checks++;
        if (pause_active !== 1'b0) begin
            failures++;
            $display("FAIL basic_pre got=%b exp=0", pause_active);
        end
        send_frame(DA, ET, OP, 16'h0003, 8, 1'b1, 1'b0, 1'b0, 16'h0003, "basic");
        checks++;
        if (pause_active !== 1'b1) begin
            failures++;
            $display("FAIL basic_rise got=%b exp=1", pause_active);
        end
        measure(n);
        checks++;
        if (n != 3 * Q) begin
            failures++;
            $display("FAIL basic_len got=%0d exp=%0d", n, 3 * Q);
        end
    endtask

    task automatic test_xon();
        send_frame(DA, ET, OP, 16'hFFFF, 8, 1'b1, 1'b0, 1'b0, 16'hFFFF, "xoff");
        tick(92);
        checks++;
        if (pause_active !== 1'b1) begin
            failures++;
            $display("FAIL xoff_hold got=%b exp=1", pause_active);
        end
        send_frame(DA, ET, OP, 16'h0000, 8, 1'b1, 1'b0, 1'b0, 16'h0000, "xon");
        checks++;
        if (pause_active !== 1'b0) begin
            failures++;
            $display("FAIL xon_active got=%b exp=0", pause_active);
        end
    endtask

    task automatic test_refresh();
        int n;
        send_frame(DA, ET, OP, 16'h0002, 8, 1'b1, 1'b0, 1'b0, 16'h0002, "ref1");
        tick(2);
        send_frame(DA, ET, OP, 16'h0002, 8, 1'b1, 1'b0, 1'b0, 16'h0002, "ref2");
        measure(n);
        checks++;
        if (n != 2 * Q) begin
            failures++;
            $display("FAIL refresh_len got=%0d exp=%0d", n, 2 * Q);
        end
    endtask

    task automatic test_discard();
        send_frame(DA, ET, OP, 16'h0007, 8, 1'b0, 1'b0, 1'b0, 16'h0000, "bad_fcs");
        send_frame(DA, ET, 16'h0002, 16'h0007, 8, 1'b1, 1'b0, 1'b0, 16'h0000, "bad_op");
        send_frame(48'h0180C2000002, ET, OP, 16'h0007, 8, 1'b1, 1'b0, 1'b0,
                   16'h0000, "bad_da");
        send_frame(DA, ET, OP, 16'h0007, 3, 1'b1, 1'b0, 1'b0, 16'h0000, "runt");
        send_frame(DA, ET, OP, 16'h0007, 7, 1'b1, 1'b0, 1'b0, 16'h0000, "short7");
        checks++;
        if (pause_active !== 1'b0) begin
            failures++;
            $display("FAIL discard_active got=%b exp=0", pause_active);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(DA, ET, 16'h0002, 16'h0009, 8, 1'b1, 1'b0, 1'b0, 16'h0000, "b2b_a");
        send_frame(DA, ET, OP, 16'h0004, 8, 1'b1, 1'b0, 1'b0, 16'h0004, "b2b_b");
        clear_timer();
    endtask

    task automatic test_gaps();
        int n;
        send_frame(DA, ET, OP, 16'h0001, 8, 1'b1, 1'b1, 1'b0, 16'h0001, "gaps");
        measure(n);
        checks++;
        if (n != Q) begin
            failures++;
            $display("FAIL gaps_len got=%0d exp=%0d", n, Q);
        end
    endtask

    task automatic test_pause_en();
        send_frame(DA, ET, OP, 16'h0010, 8, 1'b1, 1'b0, 1'b0, 16'h0010, "en_load");
        tick(5);
        pause_en = 1'b0;
        tick(1);
        checks++;
        if (pause_active !== 1'b0 || pause_quanta !== 16'd0) begin
            failures++;
            $display("FAIL en_drop got=%b/%h exp=0/0000", pause_active, pause_quanta);
        end
        pause_en = 1'b1;
        tick(1);
        send_frame(DA, ET, OP, 16'h0005, 8, 1'b1, 1'b0, 1'b1, 16'h0000, "en_last");
        checks++;
        if (pause_active !== 1'b0) begin
            failures++;
            $display("FAIL en_last_active got=%b exp=0", pause_active);
        end
        pause_en = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid();
        int n;
        send_frame(DA, ET, OP, 16'hFFFF, 8, 1'b1, 1'b0, 1'b0, 16'hFFFF, "rm_pre");
        beat({16'h1122, 48'h010000C28001}, 8'hFF, 1'b0, 1'b0);
        beat({32'h01000888, 32'h55667788}, 8'hFF, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pause_active !== 1'b0 || pause_quanta !== 16'd0
            || pause_frames !== 32'd0) begin
            failures++;
            $display("FAIL rst_async got=%b/%h/%0d exp=0/0000/0",
                     pause_active, pause_quanta, pause_frames);
        end
        model_frames = 0;
        tick(1);
        rst = 1'b0;
        tick(1);
        send_frame(DA, ET, OP, 16'h0001, 8, 1'b1, 1'b0, 1'b0, 16'h0001, "rm_post");
        measure(n);
        checks++;
        if (n != Q) begin
            failures++;
            $display("FAIL rm_len got=%0d exp=%0d", n, Q);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_xon();
        test_refresh();
        test_discard();
        test_back_to_back();
        test_gaps();
        test_pause_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
